// File: rtl/mole_game_pkg.sv
// Shared types and constants for the whack-a-mole game controller.
package mole_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    UP,
    FEEDBACK,
    OVER
  } state_t;

  localparam int NUM_HOLES = 8;
  localparam int POS_W     = $clog2(NUM_HOLES);
  localparam int SCORE_W   = 8;
  localparam int LFSR_W    = 16;

  // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value);
    return (value == '1) ? value : value + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it out of the all-zero lock-up state.
module mole_lfsr
  import mole_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              master_clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else begin
      state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_TAPS : '0);
    end
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole sequencer: spawns moles, times the visible window, judges hits,
// holds win/lose feedback for vga_display and keeps score/miss counts.
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int          TICK_DIV       = 100000,
  parameter int          MOLE_TICKS     = 1500,
  parameter int          FEEDBACK_TICKS = 500,
  parameter int          MAX_MISSES     = 3,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic               master_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit_valid,
  input  logic [POS_W-1:0]   hit_position,
  output logic [POS_W-1:0]   mole_position,
  output logic               mole_visible,
  output logic               guess_correct,
  output logic               guess_wrong,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic               game_over
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMR_MAX = (MOLE_TICKS > FEEDBACK_TICKS) ? MOLE_TICKS : FEEDBACK_TICKS;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [SCORE_W-1:0] MISS_LIMIT = SCORE_W'(MAX_MISSES);

  state_t             state;
  state_t             state_next;
  logic [LFSR_W-1:0]  lfsr;
  logic [TICK_W-1:0]  tick_cnt;
  logic [TMR_W-1:0]   timer;
  logic               tick;
  logic               up_done;
  logic               fb_done;
  logic [POS_W-1:0]   candidate;
  logic [POS_W-1:0]   spawn_pos;
  logic               unused_lfsr_bits;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .master_clk (master_clk),
    .rst_n      (rst_n),
    .state      (lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[LFSR_W-1:POS_W];

  assign tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign up_done = tick && (timer == TMR_W'(MOLE_TICKS - 1));
  assign fb_done = tick && (timer == TMR_W'(FEEDBACK_TICKS - 1));

  // Never show the mole in the same hole twice running
  assign candidate = lfsr[POS_W-1:0];
  assign spawn_pos = (candidate == mole_position) ? candidate + POS_W'(1) : candidate;

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = SPAWN;
      SPAWN:    state_next = UP;
      UP:       if (hit_valid || up_done) state_next = FEEDBACK;
      FEEDBACK: if (fb_done) state_next = (misses >= MISS_LIMIT) ? OVER : SPAWN;
      OVER:     if (start) state_next = SPAWN;
      default:  state_next = IDLE;
    endcase
  end

  // Prescaler and tick timer restart on every state change so windows are exact
  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      timer    <= '0;
    end else if ((state_next != state) || !((state == UP) || (state == FEEDBACK))) begin
      tick_cnt <= '0;
      timer    <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      timer    <= timer + TMR_W'(1);
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      mole_position <= '0;
      mole_visible  <= 1'b0;
      guess_correct <= 1'b0;
      guess_wrong   <= 1'b0;
      score         <= '0;
      misses        <= '0;
      game_over     <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score     <= '0;
            misses    <= '0;
            game_over <= 1'b0;
          end
        end
        SPAWN: begin
          mole_position <= spawn_pos;
          mole_visible  <= 1'b1;
        end
        UP: begin
          // A hit landing on the timeout cycle wins over the timeout
          if (hit_valid) begin
            mole_visible <= 1'b0;
            if (hit_position == mole_position) begin
              score         <= sat_inc(score);
              guess_correct <= 1'b1;
            end else begin
              misses      <= misses + SCORE_W'(1);
              guess_wrong <= 1'b1;
            end
          end else if (up_done) begin
            mole_visible <= 1'b0;
            misses       <= misses + SCORE_W'(1);
            guess_wrong  <= 1'b1;
          end
        end
        FEEDBACK: begin
          if (fb_done) begin
            guess_correct <= 1'b0;
            guess_wrong   <= 1'b0;
            if (misses >= MISS_LIMIT) game_over <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl: randomized play against a round-level game model.
module tb_mole_game_ctrl;

  localparam int TICK_DIV       = 4;
  localparam int MOLE_TICKS     = 5;
  localparam int FEEDBACK_TICKS = 2;
  localparam int MAX_MISSES     = 3;
  localparam int UP_CYC         = MOLE_TICKS * TICK_DIV;
  localparam int FB_CYC         = FEEDBACK_TICKS * TICK_DIV;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       master_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hit_valid = 1'b0;
  logic [2:0] hit_position = 3'd0;
  logic [2:0] mole_position;
  logic       mole_visible;
  logic       guess_correct;
  logic       guess_wrong;
  logic [7:0] score;
  logic [7:0] misses;
  logic       game_over;

  int checks = 0;
  int passed = 0;
  int exp_score = 0;
  int exp_misses = 0;
  logic [2:0]  last_pos = 3'd0;
  logic [15:0] m_lfsr;
  logic [15:0] m_prev;

  always #5 master_clk = ~master_clk;

  mole_game_ctrl #(
    .TICK_DIV       (TICK_DIV),
    .MOLE_TICKS     (MOLE_TICKS),
    .FEEDBACK_TICKS (FEEDBACK_TICKS),
    .MAX_MISSES     (MAX_MISSES),
    .LFSR_SEED      (SEED)
  ) dut (
    .master_clk    (master_clk),
    .rst_n         (rst_n),
    .start         (start),
    .hit_valid     (hit_valid),
    .hit_position  (hit_position),
    .mole_position (mole_position),
    .mole_visible  (mole_visible),
    .guess_correct (guess_correct),
    .guess_wrong   (guess_wrong),
    .score         (score),
    .misses        (misses),
    .game_over     (game_over)
  );

  // Polynomial x^16+x^14+x^13+x^11+1 stepped once per clock; m_prev is last cycle's value
  always @(posedge master_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      m_prev <= SEED;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  task automatic do_reset();
    @(negedge master_clk);
    rst_n = 1'b0;
    repeat (2) @(negedge master_clk);
    rst_n = 1'b1;
    exp_score  = 0;
    exp_misses = 0;
    last_pos   = 3'd0;
  endtask

  // Pulse start; returns at the negedge of the SPAWN cycle
  task automatic do_start();
    start = 1'b1;
    @(negedge master_clk);
    start = 1'b0;
    exp_score  = 0;
    exp_misses = 0;
    checks++;
    if (score !== 8'd0 || misses !== 8'd0 || game_over !== 1'b0 || mole_visible !== 1'b0) begin
      $display("[TB] FAIL start_clear: score=%0d misses=%0d over=%0b vis=%0b required 0/0/0/0",
               score, misses, game_over, mole_visible);
    end else passed++;
  endtask

  // Plays one mole from the SPAWN cycle. hit_at<0 means no hit; reset_at_fb>0 pulls rst_n in that feedback cycle.
  task automatic run_round(input int hit_at, input bit correct, input int reset_at_fb);
    logic [2:0] cand;
    logic [2:0] pos;
    bit         hit;
    bit         win;
    int         end_k;
    @(negedge master_clk);
    cand = m_prev[2:0];
    pos  = (cand == last_pos) ? cand + 3'd1 : cand;
    checks++;
    if (mole_visible !== 1'b1 || mole_position !== pos) begin
      $display("[TB] FAIL spawn: vis=%0b pos=%0d required vis=1 pos=%0d", mole_visible, mole_position, pos);
    end else passed++;
    checks++;
    if (mole_position === last_pos) begin
      $display("[TB] FAIL spawn_repeat: pos=%0d required different from %0d", mole_position, last_pos);
    end else passed++;
    last_pos = pos;

    hit   = (hit_at >= 0) && (hit_at < UP_CYC);
    end_k = hit ? hit_at : UP_CYC - 1;
    for (int k = 0; k <= end_k; k++) begin
      if (hit && k == hit_at) begin
        hit_valid    = 1'b1;
        hit_position = correct ? pos : pos ^ 3'($urandom_range(1, 7));
      end
      @(negedge master_clk);
      hit_valid = 1'b0;
      if (k < end_k) begin
        checks++;
        if (mole_visible !== 1'b1 || guess_correct !== 1'b0 || guess_wrong !== 1'b0) begin
          $display("[TB] FAIL up_window: cycle=%0d vis=%0b gc=%0b gw=%0b required 1/0/0",
                   k + 1, mole_visible, guess_correct, guess_wrong);
        end else passed++;
      end
    end

    win = hit && correct;
    if (win) exp_score = (exp_score == 255) ? 255 : exp_score + 1;
    else     exp_misses++;
    checks++;
    if (score !== 8'(exp_score) || misses !== 8'(exp_misses) || guess_correct !== win ||
        guess_wrong !== !win || mole_visible !== 1'b0) begin
      $display("[TB] FAIL judge: score=%0d misses=%0d gc=%0b gw=%0b vis=%0b required %0d/%0d/%0b/%0b/0",
               score, misses, guess_correct, guess_wrong, mole_visible, exp_score, exp_misses, win, !win);
    end else passed++;

    for (int f = 1; f < FB_CYC; f++) begin
      @(negedge master_clk);
      if (reset_at_fb == f) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mole_position, mole_visible, guess_correct, guess_wrong, score, misses, game_over} !== 23'd0) begin
          $display("[TB] FAIL async_reset: pos=%0d vis=%0b gc=%0b gw=%0b score=%0d misses=%0d over=%0b required all 0",
                   mole_position, mole_visible, guess_correct, guess_wrong, score, misses, game_over);
        end else passed++;
        exp_score  = 0;
        exp_misses = 0;
        last_pos   = 3'd0;
        return;
      end
      checks++;
      if (guess_correct !== win || guess_wrong !== !win || mole_position !== pos) begin
        $display("[TB] FAIL feedback_hold: cycle=%0d gc=%0b gw=%0b pos=%0d required %0b/%0b/%0d",
                 f, guess_correct, guess_wrong, mole_position, win, !win, pos);
      end else passed++;
    end

    @(negedge master_clk);
    checks++;
    if (guess_correct !== 1'b0 || guess_wrong !== 1'b0 || mole_visible !== 1'b0 ||
        game_over !== (exp_misses >= MAX_MISSES) || score !== 8'(exp_score) || misses !== 8'(exp_misses)) begin
      $display("[TB] FAIL feedback_end: gc=%0b gw=%0b vis=%0b over=%0b score=%0d misses=%0d required 0/0/0/%0b/%0d/%0d",
               guess_correct, guess_wrong, mole_visible, game_over, score, misses,
               (exp_misses >= MAX_MISSES), exp_score, exp_misses);
    end else passed++;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mole_position, mole_visible, guess_correct, guess_wrong, score, misses, game_over} !== 23'd0) begin
      $display("[TB] FAIL reset_values: pos=%0d vis=%0b score=%0d misses=%0d over=%0b required all 0",
               mole_position, mole_visible, score, misses, game_over);
    end else passed++;
    do_reset();
    for (int i = 0; i < 50; i++) begin
      hit_valid    = ($urandom_range(0, 2) == 0);
      hit_position = 3'($urandom_range(0, 7));
      @(negedge master_clk);
      checks++;
      if ({mole_position, mole_visible, guess_correct, guess_wrong, score, misses, game_over} !== 23'd0) begin
        $display("[TB] FAIL idle: cycle=%0d pos=%0d vis=%0b score=%0d misses=%0d required all 0",
                 i, mole_position, mole_visible, score, misses);
      end else passed++;
    end
    hit_valid = 1'b0;
  endtask

  task automatic test_correct_hit();
    do_reset();
    repeat ($urandom_range(0, 5)) @(negedge master_clk);
    do_start();
    run_round(3, 1'b1, -1);
    run_round($urandom_range(0, UP_CYC - 1), 1'b1, -1);
  endtask

  task automatic test_timeout();
    do_reset();
    do_start();
    run_round(-1, 1'b0, -1);
  endtask

  task automatic test_game_over();
    do_reset();
    repeat ($urandom_range(0, 7)) @(negedge master_clk);
    do_start();
    run_round($urandom_range(0, UP_CYC - 1), 1'b0, -1);
    run_round(-1, 1'b0, -1);
    run_round(-1, 1'b0, -1);
    for (int i = 0; i < 10; i++) begin
      hit_valid    = 1'b1;
      hit_position = 3'($urandom_range(0, 7));
      @(negedge master_clk);
      checks++;
      if (game_over !== 1'b1 || misses !== 8'd3 || score !== 8'(exp_score) || mole_visible !== 1'b0) begin
        $display("[TB] FAIL over_hold: over=%0b misses=%0d score=%0d vis=%0b required 1/3/%0d/0",
                 game_over, misses, score, mole_visible, exp_score);
      end else passed++;
    end
    hit_valid = 1'b0;
    do_start();
    run_round($urandom_range(0, UP_CYC - 1), 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    run_round(UP_CYC - 1, 1'b1, -1);
    run_round(UP_CYC - 1, 1'b0, -1);
    for (int i = 0; i < 6; i++) begin
      run_round($urandom_range(0, UP_CYC - 1), 1'b1, -1);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    do_start();
    for (int i = 0; i < 256; i++) begin
      run_round($urandom_range(0, UP_CYC - 1), 1'b1, -1);
    end
    checks++;
    if (score !== 8'd255) begin
      $display("[TB] FAIL saturate: score=%0d required 255", score);
    end else passed++;
    run_round($urandom_range(0, UP_CYC - 1), 1'b1, $urandom_range(1, FB_CYC - 1));
    @(negedge master_clk);
    checks++;
    if ({mole_position, mole_visible, guess_correct, guess_wrong, score, misses, game_over} !== 23'd0) begin
      $display("[TB] FAIL reset_hold: pos=%0d vis=%0b score=%0d misses=%0d required all 0",
               mole_position, mole_visible, score, misses);
    end else passed++;
    rst_n = 1'b1;
    do_start();
    run_round($urandom_range(0, UP_CYC - 1), 1'b1, -1);
  endtask

  initial begin
    test_reset();
    test_correct_hit();
    test_timeout();
    test_game_over();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
